// File: rtl/fir_mc_pipelined.sv
// fir_mc_pipelined
//   Multi-channel, fully pipelined direct-form FIR filter. Channels are
//   time-multiplexed: each has its own delay line and they share one
//   multiplier bank and adder tree. Coefficients are double-buffered. A new
//   set is written into a shadow bank and then copied into the active bank
//   on a swap. The result is rounded half-up, shifted and saturated.
//   Latency is 3 + clog2(N_TAPS) enabled cycles, at one sample per cycle.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset (clears all state)
//   ena          global enable; 0 freezes delay lines, pipeline and outputs
//   in_valid     sample present on data_in
//   in_chan      channel of the incoming sample
//   data_in      signed input sample
//   coeff_we     write coeff_data into shadow[coeff_addr] (ignores ena)
//   coeff_addr   tap index, 0 = newest sample
//   coeff_data   signed coefficient
//   coeff_swap   request shadow -> active copy at the next enabled edge
//   swap_pending swap requested but not yet executed
//   out_valid    result present (one pulse per accepted sample)
//   out_chan     channel of the result
//   data_out     signed filtered result
//   out_sat      data_out was clipped
module fir_mc_pipelined #(
    parameter int N_TAPS      = 4,
    parameter int CHANNELS    = 2,
    parameter int DATA_WIDTH  = 18,
    parameter int COEFF_WIDTH = 18,
    parameter int OUT_WIDTH   = 38,
    parameter int OUT_SHIFT   = 0,
    localparam int TW         = $clog2(N_TAPS),
    localparam int CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int ACC_WIDTH  = DATA_WIDTH + COEFF_WIDTH + TW
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ena,
    input  logic                          in_valid,
    input  logic [CW-1:0]                 in_chan,
    input  logic signed [DATA_WIDTH-1:0]  data_in,
    input  logic                          coeff_we,
    input  logic [TW-1:0]                 coeff_addr,
    input  logic signed [COEFF_WIDTH-1:0] coeff_data,
    input  logic                          coeff_swap,
    output logic                          swap_pending,
    output logic                          out_valid,
    output logic [CW-1:0]                 out_chan,
    output logic signed [OUT_WIDTH-1:0]   data_out,
    output logic                          out_sat
);

    localparam int PW = DATA_WIDTH + COEFF_WIDTH;
    localparam int NP = 1 << TW;                       // tree inputs, padded to a power of two
    localparam int RW = ACC_WIDTH + 1;                 // headroom for the rounding constant
    localparam int EW = (RW > OUT_WIDTH) ? RW : OUT_WIDTH;

    localparam logic [CW:0]              CHAN_LIM = (CW + 1)'(CHANNELS);
    localparam logic signed [RW-1:0]     RND_C    = RW'((1 << OUT_SHIFT) >> 1);
    localparam logic signed [EW-1:0]     OMAX     = {{(EW - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [EW-1:0]     OMIN     = ~OMAX;

    typedef logic signed [DATA_WIDTH-1:0]  sample_t;
    typedef logic signed [COEFF_WIDTH-1:0] coef_t;
    typedef logic signed [PW-1:0]          prod_t;
    typedef logic signed [ACC_WIDTH-1:0]   acc_t;

    // Round half-up (adds 2^(OUT_SHIFT-1), zero when OUT_SHIFT=0), then arithmetic shift.
    function automatic logic signed [RW-1:0] round_shift(input acc_t a);
        return (RW'(a) + RND_C) >>> OUT_SHIFT;
    endfunction

    // Returns {clipped, value}. When OUT_WIDTH covers the shifted range the
    // compares can never fire, so out_sat stays 0.
    function automatic logic [OUT_WIDTH:0] saturate(input logic signed [RW-1:0] v);
        logic signed [EW-1:0] e;
        e = EW'(v);
        if (e > OMAX)      return {1'b1, OMAX[OUT_WIDTH-1:0]};
        else if (e < OMIN) return {1'b1, OMIN[OUT_WIDTH-1:0]};
        else               return {1'b0, e[OUT_WIDTH-1:0]};
    endfunction

    sample_t          line_q   [CHANNELS][N_TAPS];
    coef_t            shadow_q [N_TAPS];
    coef_t            active_q [N_TAPS];
    logic             swap_pending_q;

    sample_t          tap_p1_q  [N_TAPS];
    logic             vld_p1_q;
    logic [CW-1:0]    chan_p1_q;

    prod_t            prod_p2_q [NP];
    logic             vld_p2_q;
    logic [CW-1:0]    chan_p2_q;

    acc_t             sum_q     [TW][NP];
    logic             vld_t_q   [TW];
    logic [CW-1:0]    chan_t_q  [TW];

    logic             out_valid_q;
    logic [CW-1:0]    out_chan_q;
    logic signed [OUT_WIDTH-1:0] data_out_q;
    logic             out_sat_q;

    logic             accept;
    assign accept = ena && in_valid && ({1'b0, in_chan} < CHAN_LIM);

    // Coefficient banks. The copy reads shadow_q before this edge's write lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N_TAPS; k++) begin
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
            swap_pending_q <= 1'b0;
        end else begin
            if (coeff_we) begin
                for (int k = 0; k < N_TAPS; k++)
                    if (coeff_addr == TW'(k)) shadow_q[k] <= coeff_data;
            end
            if (ena && (coeff_swap || swap_pending_q)) begin
                for (int k = 0; k < N_TAPS; k++) active_q[k] <= shadow_q[k];
                swap_pending_q <= 1'b0;
            end else if (coeff_swap) begin
                swap_pending_q <= 1'b1;
            end
        end
    end

    // S1: shift the selected channel's delay line and register its tap vector
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++)
                for (int k = 0; k < N_TAPS; k++) line_q[c][k] <= '0;
            for (int k = 0; k < N_TAPS; k++) tap_p1_q[k] <= '0;
            vld_p1_q  <= 1'b0;
            chan_p1_q <= '0;
        end else if (ena) begin
            vld_p1_q <= accept;
            if (accept) begin
                chan_p1_q <= in_chan;
                for (int c = 0; c < CHANNELS; c++) begin
                    if (in_chan == CW'(c)) begin
                        line_q[c][0] <= data_in;
                        tap_p1_q[0]  <= data_in;
                        for (int k = 1; k < N_TAPS; k++) begin
                            line_q[c][k] <= line_q[c][k-1];
                            tap_p1_q[k]  <= line_q[c][k-1];
                        end
                    end
                end
            end
        end
    end

    // S2: full-width products; padding slots are held at zero
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NP; i++) prod_p2_q[i] <= '0;
            vld_p2_q  <= 1'b0;
            chan_p2_q <= '0;
        end else if (ena) begin
            for (int i = 0; i < N_TAPS; i++)
                prod_p2_q[i] <= prod_t'(tap_p1_q[i]) * prod_t'(active_q[i]);
            for (int i = N_TAPS; i < NP; i++)
                prod_p2_q[i] <= '0;
            vld_p2_q  <= vld_p1_q;
            chan_p2_q <= chan_p1_q;
        end
    end

    // S3..S(2+TW): one adder level per stage. An odd operand meets a zero pad,
    // which makes it a plain registered pass-through.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int l = 0; l < TW; l++) begin
                for (int i = 0; i < NP; i++) sum_q[l][i] <= '0;
                vld_t_q[l]  <= 1'b0;
                chan_t_q[l] <= '0;
            end
        end else if (ena) begin
            for (int i = 0; i < NP / 2; i++)
                sum_q[0][i] <= acc_t'(prod_p2_q[2*i]) + acc_t'(prod_p2_q[2*i+1]);
            vld_t_q[0]  <= vld_p2_q;
            chan_t_q[0] <= chan_p2_q;
            for (int l = 1; l < TW; l++) begin
                for (int i = 0; i < (NP >> (l + 1)); i++)
                    sum_q[l][i] <= sum_q[l-1][2*i] + sum_q[l-1][2*i+1];
                vld_t_q[l]  <= vld_t_q[l-1];
                chan_t_q[l] <= chan_t_q[l-1];
            end
        end
    end

    // Final stage: round, shift, saturate; result fields hold across bubbles
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
            data_out_q  <= '0;
            out_sat_q   <= 1'b0;
        end else if (ena) begin
            out_valid_q <= vld_t_q[TW-1];
            if (vld_t_q[TW-1]) begin
                out_chan_q              <= chan_t_q[TW-1];
                {out_sat_q, data_out_q} <= saturate(round_shift(sum_q[TW-1][0]));
            end
        end
    end

    assign swap_pending = swap_pending_q;
    assign out_valid    = out_valid_q;
    assign out_chan     = out_chan_q;
    assign data_out     = data_out_q;
    assign out_sat      = out_sat_q;

endmodule

// File: tb/tb_fir_mc_pipelined.sv
`timescale 1ns/1ps
module tb_fir_mc_pipelined;

    localparam int LAT = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset, ena, in_valid, coeff_we, coeff_swap;
    logic [0:0]         in_chan;
    logic signed [17:0] data_in;
    logic [1:0]         coeff_addr;
    logic signed [17:0] coeff_data;

    logic               swap_pending, out_valid, out_sat;
    logic [0:0]         out_chan;
    logic signed [37:0] data_out;

    logic               swap_pending2, out_valid2, out_sat2;
    logic [0:0]         out_chan2;
    logic signed [7:0]  data_out2;

    fir_mc_pipelined dut (
        .clk(clk), .reset(reset), .ena(ena), .in_valid(in_valid), .in_chan(in_chan),
        .data_in(data_in), .coeff_we(coeff_we), .coeff_addr(coeff_addr),
        .coeff_data(coeff_data), .coeff_swap(coeff_swap), .swap_pending(swap_pending),
        .out_valid(out_valid), .out_chan(out_chan), .data_out(data_out), .out_sat(out_sat)
    );

    fir_mc_pipelined #(.OUT_WIDTH(8), .OUT_SHIFT(2)) dut_sat (
        .clk(clk), .reset(reset), .ena(ena), .in_valid(in_valid), .in_chan(in_chan),
        .data_in(data_in), .coeff_we(coeff_we), .coeff_addr(coeff_addr),
        .coeff_data(coeff_data), .coeff_swap(coeff_swap), .swap_pending(swap_pending2),
        .out_valid(out_valid2), .out_chan(out_chan2), .data_out(data_out2), .out_sat(out_sat2)
    );

    typedef struct {
        int unsigned edge_n;
        int          ch;
        longint      d;
        int          sat;
    } res_t;

    res_t        q1[$];
    res_t        q2[$];
    longint      exp_d[$];
    int          exp_c[$];
    int          exp_s[$];
    int unsigned cyc_n = 0;
    int          n_checks = 0;
    int          n_err = 0;

    // Result collector: one entry per enabled edge that leaves out_valid high.
    logic        mon_en;
    int unsigned mon_e;
    initial begin
        forever begin
            @(posedge clk);
            mon_en = ena;
            mon_e  = cyc_n;
            cyc_n++;
            #2;
            if (mon_en && out_valid)
                q1.push_back('{mon_e, int'(out_chan), longint'(data_out), int'(out_sat)});
            if (mon_en && out_valid2)
                q2.push_back('{mon_e, int'(out_chan2), longint'(data_out2), int'(out_sat2)});
        end
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input int ch, input longint d);
        in_valid = 1'b1;
        in_chan  = 1'(ch);
        data_in  = 18'(d);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic load_coeffs(input int c0, input int c1, input int c2, input int c3);
        int c[4];
        c = '{c0, c1, c2, c3};
        for (int k = 0; k < 4; k++) begin
            coeff_we   = 1'b1;
            coeff_addr = 2'(k);
            coeff_data = 18'(c[k]);
            tick();
        end
        coeff_we   = 1'b0;
        coeff_swap = 1'b1;
        tick();
        coeff_swap = 1'b0;
    endtask

    task automatic clear_q();
        q1.delete();
        q2.delete();
    endtask

    task automatic cmp_q1(input string tag);
        check({tag, ".count"}, longint'(q1.size()), longint'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && i < q1.size(); i++) begin
            check($sformatf("%s[%0d].data", tag, i), q1[i].d, exp_d[i]);
            check($sformatf("%s[%0d].chan", tag, i), longint'(q1[i].ch), longint'(exp_c[i]));
        end
    endtask

    task automatic cmp_q2(input string tag);
        check({tag, ".count"}, longint'(q2.size()), longint'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && i < q2.size(); i++) begin
            check($sformatf("%s[%0d].data", tag, i), q2[i].d, exp_d[i]);
            check($sformatf("%s[%0d].sat", tag, i), longint'(q2[i].sat), longint'(exp_s[i]));
        end
    endtask

    task automatic impulse(input string tag);
        int unsigned acc_e;
        clear_q();
        acc_e = cyc_n;
        send(0, 1);
        for (int i = 0; i < 4; i++) send(0, 0);
        idle(8);
        exp_d = '{1, 2, 3, 4, 0};
        exp_c = '{0, 0, 0, 0, 0};
        cmp_q1(tag);
        if (q1.size() > 0)
            check({tag, ".latency"}, longint'(q1[0].edge_n - acc_e), longint'(LAT - 1));
    endtask

    initial begin
        reset = 1'b1; ena = 1'b1; in_valid = 1'b0; in_chan = '0; data_in = '0;
        coeff_we = 1'b0; coeff_addr = '0; coeff_data = '0; coeff_swap = 1'b0;
        idle(2);
        check("rst.out_valid", longint'(out_valid), 0);
        check("rst.data_out", longint'(data_out), 0);
        check("rst.out_chan", longint'(out_chan), 0);
        check("rst.out_sat", longint'(out_sat), 0);
        check("rst.swap_pending", longint'(swap_pending), 0);
        check("rst.data_out2", longint'(data_out2), 0);
        reset = 1'b0;

        // Impulse response
        load_coeffs(1, 2, 3, 4);
        check("load.swap_pending", longint'(swap_pending), 0);
        impulse("impulse");

        // Channel isolation
        do_reset();
        load_coeffs(1, 1, 1, 1);
        clear_q();
        for (int i = 0; i < 5; i++) begin
            send(0, 10);
            send(1, -5);
        end
        idle(8);
        exp_d = '{10, -5, 20, -10, 30, -15, 40, -20, 40, -20};
        exp_c = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
        cmp_q1("chan_iso");

        // Coefficient swap mid-stream: shadow written during s4..s7, swap on s8
        do_reset();
        load_coeffs(1, 1, 1, 1);
        clear_q();
        for (int i = 0; i < 14; i++) begin
            in_valid   = 1'b1;
            in_chan    = '0;
            data_in    = 18'sd3;
            coeff_we   = (i >= 4 && i <= 7);
            coeff_addr = 2'(i - 4);
            coeff_data = 18'sd2;
            coeff_swap = (i == 8);
            tick();
            if (i == 8) check("swap.pending_ena1", longint'(swap_pending), 0);
        end
        in_valid = 1'b0; coeff_we = 1'b0; coeff_swap = 1'b0;
        idle(8);
        exp_d = '{3, 6, 9, 12, 12, 12, 12, 12, 24, 24, 24, 24, 24, 24};
        exp_c = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        cmp_q1("swap");

        // Swap requested while disabled stays pending until ena returns
        ena = 1'b0;
        coeff_swap = 1'b1;
        tick();
        coeff_swap = 1'b0;
        check("swap_ena0.pending1", longint'(swap_pending), 1);
        tick();
        check("swap_ena0.pending2", longint'(swap_pending), 1);
        ena = 1'b1;
        tick();
        check("swap_ena0.cleared", longint'(swap_pending), 0);

        // Rounding and saturation (OUT_WIDTH=8, OUT_SHIFT=2 instance)
        do_reset();
        load_coeffs(1, 0, 0, 0);
        clear_q();
        send(0, 6);
        send(0, 5);
        send(0, -6);
        send(0, 1000);
        send(0, -1000);
        idle(8);
        exp_d = '{2, 1, -1, 127, -128};
        exp_s = '{0, 0, 0, 1, 1};
        cmp_q2("sat");
        exp_d = '{6, 5, -6, 1000, -1000};
        exp_c = '{0, 0, 0, 0, 0};
        cmp_q1("nosat");
        for (int i = 0; i < q1.size(); i++)
            check($sformatf("nosat[%0d].sat", i), longint'(q1[i].sat), 0);

        // ena stall mid-stream; golden y = x + 2x[-1] + 3x[-2] + 4x[-3], x = 1..8
        do_reset();
        load_coeffs(1, 2, 3, 4);
        clear_q();
        for (int i = 1; i <= 6; i++) send(0, i);
        ena = 1'b0;
        in_valid = 1'b1;
        data_in = 18'sd99;
        for (int s = 0; s < 3; s++) begin
            tick();
            check($sformatf("stall%0d.out_valid", s), longint'(out_valid), 1);
            check($sformatf("stall%0d.data_out", s), longint'(data_out), 4);
        end
        ena = 1'b1;
        send(0, 7);
        send(0, 8);
        idle(8);
        exp_d = '{1, 4, 10, 20, 30, 40, 50, 60};
        exp_c = '{0, 0, 0, 0, 0, 0, 0, 0};
        cmp_q1("stall");

        // Reset with four samples in flight
        clear_q();
        for (int i = 0; i < 4; i++) send(0, 7);
        do_reset();
        check("rstmid.out_valid", longint'(out_valid), 0);
        check("rstmid.data_out", longint'(data_out), 0);
        check("rstmid.out_valid2", longint'(out_valid2), 0);
        idle(8);
        check("rstmid.no_outputs", longint'(q1.size()), 0);
        send(1, 5);
        idle(8);
        exp_d = '{0};
        exp_c = '{1};
        cmp_q1("rstmid.zero_coef");
        load_coeffs(1, 2, 3, 4);
        impulse("reimpulse");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
